lane_arbiter_2f: RTL

Round-robin scheduler that shares the single 32-bit clk_2f register stage of the PHY between two upstream lanes. Each cycle it grants at most one lane through a valid/ready handshake. It bounds consecutive grants to one lane with a burst limit, and registers the selected word with its lane tag. When nothing is granted, it emits an idle word, so the downstream flop stage always sees a defined value.

---
 rtl/lane_arbiter_2f.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lane_arbiter_2f.sv
// Two-lane round-robin arbiter feeding the shared clk_2f register stage.
// Grants at most one lane per cycle, bounds bursts under contention, registers the winner's word.
module lane_arbiter_2f #(
    parameter int          MAX_BURST = 4,
    parameter logic [31:0] IDLE_WORD = 32'hBCBC_BCBC,
    parameter int          CNT_W     = 16
) (
    input  logic             clk_2f,
    input  logic             reset,
    input  logic             pause,
    input  logic             valid_in_0,
    input  logic [31:0]      data_in_0,
    output logic             ready_0,
    input  logic             valid_in_1,
    input  logic [31:0]      data_in_1,
    output logic             ready_1,
    output logic             valid_out,
    output logic [31:0]      data_out,
    output logic             lane_out,
    output logic [CNT_W-1:0] word_cnt_0,
    output logic [CNT_W-1:0] word_cnt_1
);

    localparam int             BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]  BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]  BURST_ONE = BW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [BW-1:0]   burst_cnt_reg, burst_cnt_next;
    logic            last_reg, last_next;
    logic [1:0]      grant;

    logic            valid_out_reg;
    logic [31:0]     data_out_reg;
    logic            lane_out_reg;
    logic [CNT_W-1:0] cnt_reg [2];

    // Grant depends only on valids, pause and registered state, never on data.
    always_comb begin
        grant = 2'b00;
        if (!reset && !pause) begin
            case (state_reg)
                IDLE: begin
                    if (valid_in_0 && valid_in_1)
                        grant = last_reg ? 2'b01 : 2'b10;
                    else
                        grant = {valid_in_1, valid_in_0};
                end
                SERVE0: begin
                    if (valid_in_0 && (burst_cnt_reg < BURST_MAX || !valid_in_1))
                        grant = 2'b01;
                    else if (valid_in_1)
                        grant = 2'b10;
                end
                SERVE1: begin
                    if (valid_in_1 && (burst_cnt_reg < BURST_MAX || !valid_in_0))
                        grant = 2'b10;
                    else if (valid_in_0)
                        grant = 2'b01;
                end
                default: grant = 2'b00;
            endcase
        end
    end

    assign ready_0 = grant[0];
    assign ready_1 = grant[1];

    always_comb begin
        state_next     = IDLE;
        burst_cnt_next = '0;
        last_next      = last_reg;
        if (grant[0]) begin
            state_next     = SERVE0;
            last_next      = 1'b0;
            burst_cnt_next = BURST_ONE;
            if (state_reg == SERVE0)
                burst_cnt_next = (burst_cnt_reg == BURST_MAX) ? BURST_MAX
                                                              : burst_cnt_reg + BURST_ONE;
        end else if (grant[1]) begin
            state_next     = SERVE1;
            last_next      = 1'b1;
            burst_cnt_next = BURST_ONE;
            if (state_reg == SERVE1)
                burst_cnt_next = (burst_cnt_reg == BURST_MAX) ? BURST_MAX
                                                              : burst_cnt_reg + BURST_ONE;
        end
    end

    // last resets to 1 so lane 0 wins the first tie after reset.
    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= '0;
            last_reg      <= 1'b1;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            last_reg      <= last_next;
        end
    end

    always_ff @(posedge clk_2f or posedge reset) begin
        if (reset) begin
            valid_out_reg <= 1'b0;
            data_out_reg  <= IDLE_WORD;
            lane_out_reg  <= 1'b0;
        end else if (grant[0]) begin
            valid_out_reg <= 1'b1;
            data_out_reg  <= data_in_0;
            lane_out_reg  <= 1'b0;
        end else if (grant[1]) begin
            valid_out_reg <= 1'b1;
            data_out_reg  <= data_in_1;
            lane_out_reg  <= 1'b1;
        end else begin
            valid_out_reg <= 1'b0;
            data_out_reg  <= IDLE_WORD;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk_2f or posedge reset) begin
                if (reset)
                    cnt_reg[gi] <= '0;
                else if (grant[gi])
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
            end
        end
    endgenerate

    assign valid_out  = valid_out_reg;
    assign data_out   = data_out_reg;
    assign lane_out   = lane_out_reg;
    assign word_cnt_0 = cnt_reg[0];
    assign word_cnt_1 = cnt_reg[1];

endmodule
